// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

    localparam int unsigned DIV_WIDTH = 32;

    // Architectural result for a zero divisor: quotient all ones.
    localparam logic [DIV_WIDTH-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage divide request/result bundle between pipeline and divider.
interface div_ctrl_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             signed_op;
    logic             cancel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall_div;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, cancel, a, b,
        input  stall_div, ready, quotient, remainder
    );

    modport slave (
        input  start, signed_op, cancel, a, b,
        output stall_div, ready, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift, trial-subtract, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dividend_next
);

    logic [WIDTH:0] remSh;
    logic [WIDTH:0] diff;

    always_comb begin
        remSh = {rem, dividend[WIDTH-1]};
        diff  = remSh - {1'b0, divisor};
        // rem < divisor keeps remSh below 2*divisor, so bit WIDTH of diff is the borrow
        if (!diff[WIDTH]) begin
            rem_next      = diff[WIDTH-1:0];
            dividend_next = {dividend[WIDTH-2:0], 1'b1};
        end else begin
            rem_next      = remSh[WIDTH-1:0];
            dividend_next = {dividend[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: holds the pipeline while div_step iterates, then
// registers sign-corrected quotient (LO) and remainder (HI).
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input logic       clk,
    input logic       rst,
    div_ctrl_if.slave bus
);

    divState_t        state;
    divState_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] dvdReg;
    logic [WIDTH-1:0] dvsReg;
    logic             signQ;
    logic             signR;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] rReg;
    logic             stallDiv;
    logic             readyOut;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepDvd;
    logic             lastStep;

    assign aNeg     = bus.signed_op & bus.a[WIDTH-1];
    assign bNeg     = bus.signed_op & bus.b[WIDTH-1];
    assign absA     = aNeg ? -bus.a : bus.a;
    assign absB     = bNeg ? -bus.b : bus.b;
    assign lastStep = (cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) uStep (
        .rem          (remReg),
        .dividend     (dvdReg),
        .divisor      (dvsReg),
        .rem_next     (stepRem),
        .dividend_next(stepDvd)
    );

    always_comb begin
        stateNext = state;
        stallDiv  = 1'b0;
        readyOut  = 1'b0;
        unique case (state)
            DIV_IDLE: begin
                if (bus.start) begin
                    stallDiv  = 1'b1;
                    stateNext = (bus.b == '0) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stallDiv = 1'b1;
                if (lastStep) stateNext = DIV_DONE;
            end
            DIV_DONE: begin
                readyOut  = 1'b1;
                stateNext = DIV_IDLE;
            end
            default: stateNext = DIV_IDLE;
        endcase
        if (bus.cancel) begin
            stateNext = DIV_IDLE;
            stallDiv  = 1'b0;
            readyOut  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            remReg <= '0;
            dvdReg <= '0;
            dvsReg <= '0;
            signQ  <= 1'b0;
            signR  <= 1'b0;
            qReg   <= '0;
            rReg   <= '0;
        end else begin
            state <= stateNext;
            if (!bus.cancel) begin
                unique case (state)
                    DIV_IDLE: begin
                        if (bus.start) begin
                            if (bus.b == '0) begin
                                qReg <= WIDTH'(DIV0_Q);
                                rReg <= bus.a;
                            end else begin
                                remReg <= '0;
                                dvdReg <= absA;
                                dvsReg <= absB;
                                signQ  <= aNeg ^ bNeg;
                                signR  <= aNeg;
                                cnt    <= '0;
                            end
                        end
                    end
                    DIV_BUSY: begin
                        remReg <= stepRem;
                        dvdReg <= stepDvd;
                        cnt    <= cnt + 1'b1;
                        if (lastStep) begin
                            qReg <= signQ ? -stepDvd : stepDvd;
                            rReg <= signR ? -stepRem : stepRem;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.stall_div = stallDiv;
    assign bus.ready     = readyOut;
    assign bus.quotient  = qReg;
    assign bus.remainder = rReg;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random
// divides compared against a 64-bit arithmetic reference.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_ctrl_if #(.WIDTH(W)) bus ();

    div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;
    logic [W-1:0] expQ = '0;
    logic [W-1:0] expR = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: 64-bit signed arithmetic cannot overflow for 32-bit operands.
    function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
        longint la, lb;
        if (b == '0) begin
            q = '1;
            r = a;
            return;
        end
        la = sg ? longint'($signed(a)) : longint'(a);
        lb = sg ? longint'($signed(b)) : longint'(b);
        q  = W'(la / lb);
        r  = W'(la % lb);
    endfunction

    task automatic doDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                         input bit hold, input string tag);
        int readyAt  = -1;
        int stallCnt = 0;
        int expLat;
        logic [W-1:0] q, r;
        refDiv(a, b, sg, q, r);
        expLat = (b == '0) ? 1 : int'(W) + 1;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.signed_op = sg; bus.start = 1'b1; bus.cancel = 1'b0;
        for (int c = 0; c <= int'(W) + 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (!hold) bus.start = 1'b0;
            end
            #1;
            if (c == 0) check({tag, " ready@start"}, 64'(bus.ready), 64'(0));
            if (bus.stall_div) stallCnt++;
            if (bus.ready) begin
                readyAt = c;
                break;
            end
        end
        check({tag, " latency"}, 64'(readyAt), 64'(expLat));
        check({tag, " stallCycles"}, 64'(stallCnt), 64'(expLat));
        check({tag, " quotient"}, 64'(bus.quotient), 64'(q));
        check({tag, " remainder"}, 64'(bus.remainder), 64'(r));
        expQ = q;
        expR = r;
    endtask

    initial begin
        bit sawReady;
        rst = 1'b1;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.cancel = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", 64'(bus.stall_div), 64'(0));
        check("reset ready", 64'(bus.ready), 64'(0));
        check("reset quotient", 64'(bus.quotient), 64'(0));
        check("reset remainder", 64'(bus.remainder), 64'(0));

        doDiv(32'd100, 32'd7, 1'b0, 1'b0, "divu 100/7");
        check("divu 100/7 q const", 64'(bus.quotient), 64'(14));
        check("divu 100/7 r const", 64'(bus.remainder), 64'(2));
        doDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div -7/2");
        check("div -7/2 q const", 64'(bus.quotient), 64'(32'hFFFF_FFFD));
        check("div -7/2 r const", 64'(bus.remainder), 64'(32'hFFFF_FFFF));
        doDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "div 7/-2");
        doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div ovf");
        check("div ovf q const", 64'(bus.quotient), 64'(32'h8000_0000));
        doDiv(32'd5, 32'd0, 1'b0, 1'b0, "divu 5/0");

        // Cancel mid-divide: no ready, outputs held, restart completes normally.
        sawReady = 1'b0;
        @(negedge clk);
        bus.a = 32'd1000; bus.b = 32'd3; bus.signed_op = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) @(negedge clk);
            bus.start  = (c == 0);
            bus.cancel = (c == 10);
            #1;
            if (c >= 1 && bus.ready) sawReady = 1'b1;
            if (c == 9) check("cancel busy stall", 64'(bus.stall_div), 64'(1));
            if (c == 10) check("cancel stall", 64'(bus.stall_div), 64'(0));
            if (c == 11) begin
                check("cancel idle stall", 64'(bus.stall_div), 64'(0));
                check("cancel quotient held", 64'(bus.quotient), 64'(expQ));
                check("cancel remainder held", 64'(bus.remainder), 64'(expR));
            end
        end
        bus.cancel = 1'b0;
        check("cancel no ready", 64'(sawReady), 64'(0));
        doDiv(32'd1000, 32'd3, 1'b0, 1'b0, "after cancel");

        // Back-to-back with start held through DONE.
        doDiv(32'd12345, 32'd11, 1'b0, 1'b1, "b2b first");
        doDiv(32'hFFFF_0000, 32'h0000_0123, 1'b1, 1'b1, "b2b second");
        doDiv(32'd9, 32'd0, 1'b1, 1'b0, "b2b third");

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            int unsigned sel;
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case (sel)
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'd1;
                default: rb = $urandom;
            endcase
            doDiv(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "random");
        end

        // Reset mid-busy zeroes the results and drops the stall.
        @(negedge clk);
        bus.a = 32'd77777; bus.b = 32'd13; bus.signed_op = 1'b0; bus.cancel = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            bus.start = (c == 0);
            rst = (c == 5);
            #1;
            if (c == 6) begin
                check("rst stall", 64'(bus.stall_div), 64'(0));
                check("rst ready", 64'(bus.ready), 64'(0));
                check("rst quotient", 64'(bus.quotient), 64'(0));
                check("rst remainder", 64'(bus.remainder), 64'(0));
            end
        end
        rst = 1'b0;
        doDiv(32'd77777, 32'd13, 1'b0, 1'b0, "after rst");

        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("final ready low", 64'(bus.ready), 64'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
